// File: rtl/wave_clk_divider.sv
// wave_clk_divider: synthesizable stimulus clock stage.
// Derives medium/slow divided clocks from clk during a bounded run
// (IDLE -> RUN -> DONE) and exposes the elapsed run cycle count.
// Optional build macro: WAVE_GRAY_CNT_EN -- cycle_cnt is Gray coded.
// Divided clocks are plain registered data, so downstream logic should
// consume med_tick/slow_tick as enables instead of clocking on them.
module wave_clk_divider #(
  parameter int MED_HALF   = 50,
  parameter int SLOW_HALF  = 500,
  parameter int RUN_CYCLES = 10000,
  localparam int CNT_W     = $clog2(RUN_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  output logic             med_clk_o,
  output logic             slow_clk_o,
  output logic             med_tick,
  output logic             slow_tick,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt
);

  // +1 keeps the widths >= 1 when a half period is 1
  localparam int MW = $clog2(MED_HALF + 1);
  localparam int SW = $clog2(SLOW_HALF + 1);

  localparam logic [MW-1:0]    MED_LAST  = MW'(MED_HALF - 1);
  localparam logic [SW-1:0]    SLOW_LAST = SW'(SLOW_HALF - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e           state_q,     state_d;
  logic [MW-1:0]    med_cnt_q,   med_cnt_d;
  logic [SW-1:0]    slow_cnt_q,  slow_cnt_d;
  logic [CNT_W-1:0] bin_cnt_q,   bin_cnt_d;
  logic [CNT_W-1:0] cyc_out_q,   cyc_out_d;
  logic             med_clk_q,   med_clk_d;
  logic             slow_clk_q,  slow_clk_d;
  logic             med_tick_q,  med_tick_d;
  logic             slow_tick_q, slow_tick_d;
  logic             running_q,   running_d;
  logic             done_q,      done_d;

  // Next state: stop dominates start everywhere; start ignored while running
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (stop)       state_d = S_IDLE;
        else if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop)                       state_d = S_IDLE;
        else if (bin_cnt_q == RUN_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        if (stop)       state_d = S_IDLE;
        else if (start) state_d = S_RUN;
      end
      default:          state_d = S_IDLE;
    endcase
  end

  // Datapath next values, keyed off the transition just decided
  always_comb begin
    med_cnt_d   = med_cnt_q;
    slow_cnt_d  = slow_cnt_q;
    bin_cnt_d   = bin_cnt_q;
    med_clk_d   = med_clk_q;
    slow_clk_d  = slow_clk_q;
    med_tick_d  = 1'b0;
    slow_tick_d = 1'b0;

    if (state_d == S_IDLE || (state_d == S_RUN && state_q != S_RUN)) begin
      // Clear on abort/idle, and on the run entry edge (E0)
      med_cnt_d  = '0;
      slow_cnt_d = '0;
      bin_cnt_d  = '0;
      med_clk_d  = 1'b0;
      slow_clk_d = 1'b0;
    end else if (state_q == S_RUN) begin
      // Run edge after E0; the edge entering DONE still toggles the dividers
      if (med_cnt_q == MED_LAST) begin
        med_cnt_d  = '0;
        med_clk_d  = ~med_clk_q;
        med_tick_d = 1'b1;
      end else begin
        med_cnt_d  = med_cnt_q + 1'b1;
      end
      if (slow_cnt_q == SLOW_LAST) begin
        slow_cnt_d  = '0;
        slow_clk_d  = ~slow_clk_q;
        slow_tick_d = 1'b1;
      end else begin
        slow_cnt_d  = slow_cnt_q + 1'b1;
      end
      bin_cnt_d = bin_cnt_q + 1'b1;
      // Ticks are a RUN-only qualifier, so the DONE-entry edge drops them
      if (state_d != S_RUN) begin
        med_tick_d  = 1'b0;
        slow_tick_d = 1'b0;
      end
    end

    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
`ifdef WAVE_GRAY_CNT_EN
    cyc_out_d = bin_cnt_d ^ (bin_cnt_d >> 1);
`else
    cyc_out_d = bin_cnt_d;
`endif
  end

  // State and output registers; every output comes straight from a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      med_cnt_q   <= '0;
      slow_cnt_q  <= '0;
      bin_cnt_q   <= '0;
      cyc_out_q   <= '0;
      med_clk_q   <= 1'b0;
      slow_clk_q  <= 1'b0;
      med_tick_q  <= 1'b0;
      slow_tick_q <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      med_cnt_q   <= med_cnt_d;
      slow_cnt_q  <= slow_cnt_d;
      bin_cnt_q   <= bin_cnt_d;
      cyc_out_q   <= cyc_out_d;
      med_clk_q   <= med_clk_d;
      slow_clk_q  <= slow_clk_d;
      med_tick_q  <= med_tick_d;
      slow_tick_q <= slow_tick_d;
      running_q   <= running_d;
      done_q      <= done_d;
    end
  end

  assign med_clk_o  = med_clk_q;
  assign slow_clk_o = slow_clk_q;
  assign med_tick   = med_tick_q;
  assign slow_tick  = slow_tick_q;
  assign running    = running_q;
  assign done       = done_q;
  assign cycle_cnt  = cyc_out_q;

endmodule

// File: tb/tb_wave_clk_divider.sv
// Bench for wave_clk_divider: three parameterizations share one stimulus
// stream; each is checked every cycle against an arithmetic model that
// tracks only (state, edges since run entry).
module tb_wave_clk_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;

  always #5 clk = ~clk;

  wire [2:0]  med, slow, mtk, stk, run, dn;
  wire [13:0] cnt0;
  wire [4:0]  cnt1;
  wire [3:0]  cnt2;

  wave_clk_divider u_def (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .med_clk_o(med[0]), .slow_clk_o(slow[0]), .med_tick(mtk[0]), .slow_tick(stk[0]),
    .running(run[0]), .done(dn[0]), .cycle_cnt(cnt0));

  wave_clk_divider #(.MED_HALF(3), .SLOW_HALF(7), .RUN_CYCLES(20)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .med_clk_o(med[1]), .slow_clk_o(slow[1]), .med_tick(mtk[1]), .slow_tick(stk[1]),
    .running(run[1]), .done(dn[1]), .cycle_cnt(cnt1));

  wave_clk_divider #(.MED_HALF(1), .SLOW_HALF(2), .RUN_CYCLES(8)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .med_clk_o(med[2]), .slow_clk_o(slow[2]), .med_tick(mtk[2]), .slow_tick(stk[2]),
    .running(run[2]), .done(dn[2]), .cycle_cnt(cnt2));

  // Model: st 0=IDLE 1=RUN 2=DONE; k = edges since run entry
  int mh[3] = '{50, 3, 1};
  int sh[3] = '{500, 7, 2};
  int rc[3] = '{10000, 20, 8};
  int st[3];
  int k[3];
  int n_cmp = 0;
  int n_err = 0;

  function automatic int enc(int v);
`ifdef WAVE_GRAY_CNT_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  task automatic chk(string ph, int inst, string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s/u%0d/%s: got %0d expected %0d", ph, inst, nm, act, exp);
    end
  endtask

  task automatic model_edge(bit s, bit p);
    for (int i = 0; i < 3; i++) begin
      if (p) begin
        st[i] = 0; k[i] = 0;
      end else if (st[i] == 1) begin
        k[i]++;
        if (k[i] == rc[i]) st[i] = 2;
      end else if (s) begin
        st[i] = 1; k[i] = 0;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      st[i] = 0; k[i] = 0;
    end
  endtask

  task automatic check_all(string ph);
    logic [31:0] acnt;
    for (int i = 0; i < 3; i++) begin
      acnt = (i == 0) ? 32'(cnt0) : (i == 1) ? 32'(cnt1) : 32'(cnt2);
      chk(ph, i, "med_clk",   32'(med[i]),  32'((k[i] / mh[i]) % 2));
      chk(ph, i, "slow_clk",  32'(slow[i]), 32'((k[i] / sh[i]) % 2));
      chk(ph, i, "med_tick",  32'(mtk[i]),  32'(st[i] == 1 && k[i] > 0 && k[i] % mh[i] == 0));
      chk(ph, i, "slow_tick", 32'(stk[i]),  32'(st[i] == 1 && k[i] > 0 && k[i] % sh[i] == 0));
      chk(ph, i, "running",   32'(run[i]),  32'(st[i] == 1));
      chk(ph, i, "done",      32'(dn[i]),   32'(st[i] == 2));
      chk(ph, i, "cycle_cnt", acnt,         32'(enc(k[i])));
    end
  endtask

  // Drive inputs, take one edge, then compare 1ns after it
  task automatic step(string ph, bit s, bit p);
    start = s;
    stop  = p;
    @(posedge clk);
    model_edge(s, p);
    #1;
    check_all(ph);
  endtask

  // Async reset pulse placed away from any clock edge
  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    #2 rst_n = 1'b1;
  endtask

  int  tog;
  logic prev;

  initial begin
    model_reset();
    // Reset asserted between edges clears outputs immediately
    #3 rst_n = 1'b0;
    #1 check_all("rst_now");
    @(posedge clk); #1 check_all("rst_hold");
    @(negedge clk) rst_n = 1'b1;
    repeat (5) step("idle", 1'b0, 1'b0);

    // Full default run from a one-cycle start pulse
    step("e0", 1'b1, 1'b0);
    tog  = 0;
    prev = med[0];
    for (int n = 0; n < 10005; n++) begin
      step("run", 1'b0, 1'b0);
      if (med[0] !== prev) tog++;
      prev = med[0];
    end
    chk("run", 0, "med_toggles", 32'(tog), 32'(rc[0] / mh[0]));

    // Restart from DONE, then start+stop together at E37
    step("restart", 1'b1, 1'b0);
    repeat (36) step("pre_stop", 1'b0, 1'b0);
    step("stop37", 1'b1, 1'b1);
    repeat (3) step("post_stop", 1'b0, 1'b0);

    // Async reset in the middle of a run
    step("e0b", 1'b1, 1'b0);
    repeat (10) step("runb", 1'b0, 1'b0);
    async_reset();
    repeat (3) step("post_rst", 1'b0, 1'b0);

    // Random start/stop traffic
    for (int n = 0; n < 3000; n++) begin
      step("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
      if (n == 1500) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
